arb_mux: RTL and testbench
==========================

# arb_mux

Round-robin arbitrating multiplexer: gathers words from N = 2**CW source blocks packed on one wide bus and forwards one word per cycle to a single registered output with valid/ready handshake. It is the collecting counterpart of `demux`: where `demux` scatters one word to block b(s), `arb_mux` picks a block b(k), forwards its word and reports k on `s`. It sits at pipeline merge points, such as several units writing back through one port.

## Interface

Parameters:
- DW, 1: width of each data block and of output `o`
- CW, 2: width of index `s`; N = 2**CW source blocks

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous reset, active low
- i  input  DW*N  packed source data {b(0), b(1), ..., b(N-1)}; b(k) = i[DW*(N-k)-1 : DW*(N-1-k)]
- v  input  N  request: v[k]=1 means b(k) holds a valid word (bit k ↔ block b(k))
- ack  output  N  combinational grant: ack[k]=1 means b(k) is consumed this cycle
- o  output  DW  registered output word
- s  output  CW  registered binary index of the block that supplied `o`
- ov  output  1  registered output valid
- ordy  input  1  downstream ready

## Operation

- State: output register {o, s, ov}; round-robin pointer ptr [CW].
- Load enable: ld = (!ov || ordy) && (v != 0). Output slot is free, or it is emptied this cycle.
- Winner k: first index with v[k]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- When ld=1:
  - ack[k]=1, all other ack bits 0.
  - On the next edge: o<=b(k), s<=k, ov<=1, ptr<=(k+1) mod N (wraps from N-1 to 0).
- When ld=0: ack=0 and ptr holds.
  - If ov && ordy: ov<=0. o and s hold their last value and are don't-care.
  - Otherwise o, s and ov hold.
- Source rule: v[k] and b(k) stay stable until ack[k] is seen. A source may drop v[k] only in the cycle after its ack, or while it is not yet acked. The block does not check this rule.
- Downstream rule: a transfer occurs when ov && ordy. While ov && !ordy, o and s stay stable.
- Simultaneous drain and load (ov && ordy && v!=0): the output is replaced back-to-back with no bubble. ov stays 1.
- Fairness: a continuously requesting source is granted within N loads.
- Reset (rst_n=0 at an edge): ov=0, o=0, s=0, ptr=0 after that edge. While rst_n=0, ack is forced to 0 combinationally. A request pending at reset is neither acked nor lost; it is re-arbitrated from ptr=0 after release.
- N=2 (CW=1) and DW=1 are legal. Only the winner's data reaches `o`; other blocks are ignored.

## Timing

- Latency: a word acked in cycle t appears on o/s with ov=1 after the edge ending cycle t, i.e. in cycle t+1.
- Throughput: one word per cycle while ordy=1 and any v is set.
- ack depends combinationally on v, ptr, ov, ordy and rst_n. There is no combinational path from i to any output.
- ordy=0 with ov=1 stalls: ack=0 and all state holds.
- First cycle after reset release: ov=0, so any v produces an ack in that same cycle.

## Test plan

DW=8, CW=2 throughout.

- **Reset:** drive rst_n=0 with v=4'b1111 and ordy=1 -> ack=0; after the edge ov=0, o=0, s=0. Release -> same cycle ack[0]=1; next cycle o=b(0), s=0, ov=1.
- **Round robin under full load:** v=4'b1111, b(k)=8'hA0+k, ordy=1 continuously -> s sequence 0,1,2,3,0,1 with o=A0,A1,A2,A3,A0,A1. Exactly one ack bit per cycle, no bubbles.
- **Pointer skip and wrap:** after granting k=2, set v=4'b0011 -> next grant k=0 (wrap), then k=1, then k=0.
- **Backpressure:** ov=1 with o=8'h55, s=3 and ordy=0 for 3 cycles while v=4'b0100 -> ack=0 throughout, o/s/ov held. Raise ordy -> ack[2]=1 that cycle; next cycle o=b(2), s=2.
- **Drain to empty:** single request v=4'b1000, b(3)=8'h3C -> ack[3] once. Then drop v with ordy=1 -> ov goes 1 for one cycle and then 0; ptr=0 afterwards, so next v=4'b1001 grants k=0.
- **Reset mid-stream:** assert rst_n=0 while ov=1, s=2 and v=4'b1111 -> ack=0 in that cycle; after the edge ov=0, ptr=0. After release, the first grant is k=0.

Source files
------------

// File: rtl/arb_mux.sv
// arb_mux: round-robin arbitrating multiplexer.
// Collects one word per cycle from N = 2**CW packed source blocks and forwards
// it to a registered output {o, s, ov} with a valid/ready handshake.
module arb_mux #(
    parameter int DW = 1,
    parameter int CW = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW*(2**CW)-1:0]    i,
    input  logic [(2**CW)-1:0]       v,
    output logic [(2**CW)-1:0]       ack,
    output logic [DW-1:0]            o,
    output logic [CW-1:0]            s,
    output logic                     ov,
    input  logic                     ordy
);

    localparam int N = 2**CW;

    // Output register and round-robin pointer
    logic [DW-1:0] o_q,   o_d;
    logic [CW-1:0] s_q,   s_d;
    logic          ov_q,  ov_d;
    logic [CW-1:0] ptr_q, ptr_d;

    // Combinational arbitration results
    logic [DW-1:0] blk_s [N];
    logic [CW-1:0] win_s;
    logic [CW-1:0] idx_s;
    logic          found_s;
    logic          ld_s;
    logic [N-1:0]  ack_s;

    // Unpack the source bus: b(0) sits in the most significant block.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            blk_s[k] = i[DW*(N-1-k) +: DW];
        end
    end

    // Scan requests starting at ptr, wrapping modulo N; the first hit wins.
    // The CW-bit addition wraps naturally from N-1 back to 0.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int j = 0; j < N; j++) begin
            idx_s = ptr_q + CW'(j);
            if (!found_s && v[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Load when the output slot is free or drains this cycle; reset masks the grant
    // so a pending request is neither acked nor lost.
    always_comb begin
        ld_s  = rst_n && (!ov_q || ordy) && found_s;
        ack_s = '0;
        if (ld_s) begin
            ack_s[win_s] = 1'b1;
        end else begin
            ack_s = '0;
        end
    end

    // Next-state: load the winner, or clear valid on a drain, otherwise hold.
    always_comb begin
        o_d   = o_q;
        s_d   = s_q;
        ov_d  = ov_q;
        ptr_d = ptr_q;
        if (ld_s) begin
            o_d   = blk_s[win_s];
            s_d   = win_s;
            ov_d  = 1'b1;
            ptr_d = win_s + CW'(1);
        end else if (ov_q && ordy) begin
            ov_d  = 1'b0;
        end else begin
            ov_d  = ov_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q   <= '0;
            s_q   <= '0;
            ov_q  <= 1'b0;
            ptr_q <= '0;
        end else begin
            o_q   <= o_d;
            s_q   <= s_d;
            ov_q  <= ov_d;
            ptr_q <= ptr_d;
        end
    end

    assign ack = ack_s;
    assign o   = o_q;
    assign s   = s_q;
    assign ov  = ov_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed self-checking bench for arb_mux with DW=8, CW=2.
// Inputs change 1 time unit after a rising edge; ack is sampled 1 unit later,
// registered outputs are sampled 1 unit after the following rising edge.
module tb_arb_mux;

    logic        clk;
    logic        rst_n;
    logic [31:0] i;
    logic [3:0]  v;
    logic [3:0]  ack;
    logic [7:0]  o;
    logic [1:0]  s;
    logic        ov;
    logic        ordy;

    int checks;
    int failures;

    arb_mux #(.DW(8), .CW(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .i    (i),
        .v    (v),
        .ack  (ack),
        .o    (o),
        .s    (s),
        .ov   (ov),
        .ordy (ordy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pack4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; v = 4'b1111; ordy = 1'b1;
        i = pack4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        #1;
        checks++;
        if (ack !== 4'b0000) begin
            failures++; $display("FAIL reset_ack got=%b exp=%b", ack, 4'b0000);
        end
        @(posedge clk); #1;
        checks++;
        if ({o, s, ov} !== {8'h00, 2'd0, 1'b0}) begin
            failures++; $display("FAIL reset_regs got o=%h s=%0d ov=%b exp o=00 s=0 ov=0", o, s, ov);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b0001) begin
            failures++; $display("FAIL reset_release_ack got=%b exp=%b", ack, 4'b0001);
        end
        @(posedge clk); #1;
        checks++;
        if ({o, s, ov} !== {8'hA0, 2'd0, 1'b1}) begin
            failures++; $display("FAIL reset_release_out got o=%h s=%0d ov=%b exp o=a0 s=0 ov=1", o, s, ov);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [1:0] exp_s   [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [7:0] exp_o   [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};
        rst_n = 1'b0; v = 4'b0000; ordy = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; v = 4'b1111;
        i = pack4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (ack !== exp_ack[c]) begin
                failures++; $display("FAIL rr_ack[%0d] got=%b exp=%b", c, ack, exp_ack[c]);
            end
            @(posedge clk); #1;
            checks++;
            if ({o, s, ov} !== {exp_o[c], exp_s[c], 1'b1}) begin
                failures++; $display("FAIL rr_out[%0d] got o=%h s=%0d ov=%b exp o=%h s=%0d ov=1",
                                     c, o, s, ov, exp_o[c], exp_s[c]);
            end
        end
    endtask

    task automatic test_skip_wrap();
        // ptr is 2 after the round-robin run: grant k=2 first.
        logic [3:0] exp_ack [4] = '{4'b0100, 4'b0001, 4'b0010, 4'b0001};
        logic [1:0] exp_s   [4] = '{2'd2, 2'd0, 2'd1, 2'd0};
        logic [7:0] exp_o   [4] = '{8'hC2, 8'hC0, 8'hC1, 8'hC0};
        i = pack4(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        ordy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            v = (c == 0) ? 4'b0100 : 4'b0011;
            #1;
            checks++;
            if (ack !== exp_ack[c]) begin
                failures++; $display("FAIL skip_ack[%0d] got=%b exp=%b", c, ack, exp_ack[c]);
            end
            @(posedge clk); #1;
            checks++;
            if ({o, s, ov} !== {exp_o[c], exp_s[c], 1'b1}) begin
                failures++; $display("FAIL skip_out[%0d] got o=%h s=%0d ov=%b exp o=%h s=%0d ov=1",
                                     c, o, s, ov, exp_o[c], exp_s[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        // ptr is 1: scan 1,2,3 lands on k=3 carrying 8'h55.
        i = pack4(8'h00, 8'h00, 8'h77, 8'h55);
        v = 4'b1000; ordy = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({o, s, ov} !== {8'h55, 2'd3, 1'b1}) begin
            failures++; $display("FAIL bp_setup got o=%h s=%0d ov=%b exp o=55 s=3 ov=1", o, s, ov);
        end
        v = 4'b0100; ordy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (ack !== 4'b0000) begin
                failures++; $display("FAIL bp_stall_ack[%0d] got=%b exp=%b", c, ack, 4'b0000);
            end
            @(posedge clk); #1;
            checks++;
            if ({o, s, ov} !== {8'h55, 2'd3, 1'b1}) begin
                failures++; $display("FAIL bp_hold[%0d] got o=%h s=%0d ov=%b exp o=55 s=3 ov=1", c, o, s, ov);
            end
        end
        ordy = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b0100) begin
            failures++; $display("FAIL bp_release_ack got=%b exp=%b", ack, 4'b0100);
        end
        @(posedge clk); #1;
        checks++;
        if ({o, s, ov} !== {8'h77, 2'd2, 1'b1}) begin
            failures++; $display("FAIL bp_release_out got o=%h s=%0d ov=%b exp o=77 s=2 ov=1", o, s, ov);
        end
    endtask

    task automatic test_drain();
        // ptr is 3 after granting k=2.
        i = pack4(8'h11, 8'h00, 8'h00, 8'h3C);
        v = 4'b1000; ordy = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b1000) begin
            failures++; $display("FAIL drain_ack got=%b exp=%b", ack, 4'b1000);
        end
        @(posedge clk); #1;
        checks++;
        if ({o, s, ov} !== {8'h3C, 2'd3, 1'b1}) begin
            failures++; $display("FAIL drain_load got o=%h s=%0d ov=%b exp o=3c s=3 ov=1", o, s, ov);
        end
        v = 4'b0000;
        #1;
        checks++;
        if (ack !== 4'b0000) begin
            failures++; $display("FAIL drain_idle_ack got=%b exp=%b", ack, 4'b0000);
        end
        @(posedge clk); #1;
        checks++;
        if (ov !== 1'b0) begin
            failures++; $display("FAIL drain_empty got ov=%b exp ov=0", ov);
        end
        @(posedge clk); #1;
        checks++;
        if (ov !== 1'b0) begin
            failures++; $display("FAIL drain_stay_empty got ov=%b exp ov=0", ov);
        end
        v = 4'b1001;
        #1;
        checks++;
        if (ack !== 4'b0001) begin
            failures++; $display("FAIL drain_wrap_ack got=%b exp=%b", ack, 4'b0001);
        end
        @(posedge clk); #1;
        checks++;
        if ({o, s, ov} !== {8'h11, 2'd0, 1'b1}) begin
            failures++; $display("FAIL drain_wrap_out got o=%h s=%0d ov=%b exp o=11 s=0 ov=1", o, s, ov);
        end
    endtask

    task automatic test_reset_mid();
        // ptr is 1: a lone request on k=2 puts s=2 on the output.
        i = pack4(8'hD0, 8'hD1, 8'hD2, 8'hD3);
        v = 4'b0100; ordy = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({o, s, ov} !== {8'hD2, 2'd2, 1'b1}) begin
            failures++; $display("FAIL mid_setup got o=%h s=%0d ov=%b exp o=d2 s=2 ov=1", o, s, ov);
        end
        rst_n = 1'b0; v = 4'b1111;
        #1;
        checks++;
        if (ack !== 4'b0000) begin
            failures++; $display("FAIL mid_reset_ack got=%b exp=%b", ack, 4'b0000);
        end
        @(posedge clk); #1;
        checks++;
        if ({o, s, ov} !== {8'h00, 2'd0, 1'b0}) begin
            failures++; $display("FAIL mid_reset_regs got o=%h s=%0d ov=%b exp o=00 s=0 ov=0", o, s, ov);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b0001) begin
            failures++; $display("FAIL mid_first_ack got=%b exp=%b", ack, 4'b0001);
        end
        @(posedge clk); #1;
        checks++;
        if ({o, s, ov} !== {8'hD0, 2'd0, 1'b1}) begin
            failures++; $display("FAIL mid_first_out got o=%h s=%0d ov=%b exp o=d0 s=0 ov=1", o, s, ov);
        end
    endtask

    // Run all scenarios in order and report.
    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; v = 4'b0000; ordy = 1'b0; i = 32'h0000_0000;
        @(posedge clk); #1;
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_backpressure();
        test_drain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
